trig_lut_seq: RTL

Multi-channel, time-multiplexed sine/cosine engine for the cube rotation path. It takes one packed vector of `CHANNELS` integer-degree angles and returns `CHANNELS` signed results scaled by 100. Internally it uses a 91-entry quarter-wave table plus quadrant folding. It sits between the angle accumulators and the rotation-matrix multipliers and replaces per-axis full-circle lookup with one shared, sequenced lookup and a start/done handshake.

---
 rtl/trig_pkg.sv | 58 +++++
 rtl/trig_quarter_rom.sv | 16 +
 rtl/trig_lut_seq.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/trig_pkg.sv
// -----------------------------------------------------------------------------
// trig_pkg
// Shared constants, FSM state type and the quarter-wave cosine table for the
// sequenced sine/cosine engine (trig_lut_seq).
//   cos_q(idx) : 100*cos(idx degrees), truncated toward zero, idx 0..90.
//                Any idx above 90 returns 0.
// -----------------------------------------------------------------------------
package trig_pkg;

    localparam int TRIG_SCALE  = 100;
    localparam int DEG_FULL    = 360;
    localparam int DEG_QUARTER = 90;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FOLD = 2'd1,
        ST_LOOK = 2'd2
    } trigState_e;

    function automatic logic [7:0] cos_q(input logic [6:0] idx);
        case (idx)
            7'd0:                                     cos_q = 8'd100;
            7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8: cos_q = 8'd99;
            7'd9, 7'd10, 7'd11:                       cos_q = 8'd98;
            7'd12, 7'd13, 7'd14:                      cos_q = 8'd97;
            7'd15, 7'd16:                             cos_q = 8'd96;
            7'd17, 7'd18:                             cos_q = 8'd95;
            7'd19:                                    cos_q = 8'd94;
            7'd20, 7'd21:                             cos_q = 8'd93;
            7'd22, 7'd23:                             cos_q = 8'd92;
            7'd24: cos_q = 8'd91;  7'd25: cos_q = 8'd90;
            7'd26, 7'd27:                             cos_q = 8'd89;
            7'd28: cos_q = 8'd88;  7'd29: cos_q = 8'd87;  7'd30: cos_q = 8'd86;
            7'd31: cos_q = 8'd85;  7'd32: cos_q = 8'd84;  7'd33: cos_q = 8'd83;
            7'd34: cos_q = 8'd82;  7'd35: cos_q = 8'd81;  7'd36: cos_q = 8'd80;
            7'd37: cos_q = 8'd79;  7'd38: cos_q = 8'd78;  7'd39: cos_q = 8'd77;
            7'd40: cos_q = 8'd76;  7'd41: cos_q = 8'd75;  7'd42: cos_q = 8'd74;
            7'd43: cos_q = 8'd73;  7'd44: cos_q = 8'd71;  7'd45: cos_q = 8'd70;
            7'd46: cos_q = 8'd69;  7'd47: cos_q = 8'd68;  7'd48: cos_q = 8'd66;
            7'd49: cos_q = 8'd65;  7'd50: cos_q = 8'd64;  7'd51: cos_q = 8'd62;
            7'd52: cos_q = 8'd61;  7'd53: cos_q = 8'd60;  7'd54: cos_q = 8'd58;
            7'd55: cos_q = 8'd57;  7'd56: cos_q = 8'd55;  7'd57: cos_q = 8'd54;
            7'd58: cos_q = 8'd52;  7'd59: cos_q = 8'd51;  7'd60: cos_q = 8'd50;
            7'd61: cos_q = 8'd48;  7'd62: cos_q = 8'd46;  7'd63: cos_q = 8'd45;
            7'd64: cos_q = 8'd43;  7'd65: cos_q = 8'd42;  7'd66: cos_q = 8'd40;
            7'd67: cos_q = 8'd39;  7'd68: cos_q = 8'd37;  7'd69: cos_q = 8'd35;
            7'd70: cos_q = 8'd34;  7'd71: cos_q = 8'd32;  7'd72: cos_q = 8'd30;
            7'd73: cos_q = 8'd29;  7'd74: cos_q = 8'd27;  7'd75: cos_q = 8'd25;
            7'd76: cos_q = 8'd24;  7'd77: cos_q = 8'd22;  7'd78: cos_q = 8'd20;
            7'd79: cos_q = 8'd19;  7'd80: cos_q = 8'd17;  7'd81: cos_q = 8'd15;
            7'd82: cos_q = 8'd13;  7'd83: cos_q = 8'd12;  7'd84: cos_q = 8'd10;
            7'd85: cos_q = 8'd8;   7'd86: cos_q = 8'd6;   7'd87: cos_q = 8'd5;
            7'd88: cos_q = 8'd3;   7'd89: cos_q = 8'd1;
            default:                                  cos_q = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/trig_quarter_rom.sv
// -----------------------------------------------------------------------------
// trig_quarter_rom
// Combinational 91 x 8 quarter-wave cosine ROM (0..90 degrees).
//   idx [6:0] in  : table index in degrees; values above 90 read as 0
//   mag [7:0] out : unsigned magnitude, 100*cos(idx) truncated
// -----------------------------------------------------------------------------
module trig_quarter_rom
    import trig_pkg::*;
(
    input  logic [6:0] idx,
    output logic [7:0] mag
);

    assign mag = (idx > 7'(DEG_QUARTER)) ? 8'd0 : cos_q(idx);

endmodule

// File: rtl/trig_lut_seq.sv
// -----------------------------------------------------------------------------
// trig_lut_seq
// Time-multiplexed sine/cosine engine. One request carries CHANNELS angles;
// each channel takes two cycles (FOLD: reduce and fold into the quarter
// table, LOOK: read table, apply sign, write the result slot).
//   clk      in  : clock, rising edge
//   rst_n    in  : asynchronous active-low reset
//   start    in  : request strobe, only honoured in IDLE
//   mode     in  : 0 = cosine, 1 = sine (captured with start)
//   angles   in  : CHANNELS x ANG_W unsigned degrees (captured with start)
//   busy     out : high while a request is in progress
//   done     out : one-cycle pulse after the last slot is written
//   results  out : CHANNELS x OUT_W signed results scaled by 100
// -----------------------------------------------------------------------------
module trig_lut_seq
    import trig_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int ANG_W    = 10,
    parameter int OUT_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      mode,
    input  logic [CHANNELS*ANG_W-1:0] angles,
    output logic                      busy,
    output logic                      done,
    output logic [CHANNELS*OUT_W-1:0] results
);

    localparam int CNT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    // One spare bit so the +270 sine offset cannot overflow.
    localparam int WRK_W = ANG_W + 1;
    // Conditional subtractions needed to bring any ANG_W-bit angle below 360.
    localparam int NSUB  = ((2 ** ANG_W) + DEG_FULL - 1) / DEG_FULL - 1;
    localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CHANNELS - 1);

    trigState_e                state;
    logic [CNT_W-1:0]          chan;
    logic [CHANNELS*ANG_W-1:0] angCap;
    logic                      modeCap;
    logic [6:0]                idxP1;
    logic                      negP1;

    logic [ANG_W-1:0]          curAng;
    logic [WRK_W-1:0]          red;
    logic [6:0]                foldIdx;
    logic                      foldNeg;
    logic [7:0]                mag;
    logic [OUT_W-1:0]          magExt;
    logic signed [OUT_W-1:0]   slotVal;
    logic                      accept;

    assign accept = (state == ST_IDLE) && start;
    assign curAng = angCap[chan*ANG_W +: ANG_W];

    // FOLD stage: modulo-360 reduction, sine offset, quadrant fold.
    always_comb begin
        red = WRK_W'(curAng);
        for (int k = 0; k < NSUB; k++) begin
            if (red >= WRK_W'(DEG_FULL)) red = red - WRK_W'(DEG_FULL);
        end
        // sin(a) = cos(a + 270)
        if (modeCap) begin
            red = red + WRK_W'(270);
            if (red >= WRK_W'(DEG_FULL)) red = red - WRK_W'(DEG_FULL);
        end
        foldIdx = 7'd0;
        foldNeg = 1'b0;
        if (red <= WRK_W'(DEG_QUARTER)) begin
            foldIdx = 7'(red);
        end else if (red <= WRK_W'(180)) begin
            foldIdx = 7'(WRK_W'(180) - red);
            foldNeg = 1'b1;
        end else if (red <= WRK_W'(270)) begin
            foldIdx = 7'(red - WRK_W'(180));
            foldNeg = 1'b1;
        end else begin
            foldIdx = 7'(WRK_W'(DEG_FULL) - red);
        end
    end

    // LOOK stage: table read and sign application; -0 stays 0.
    trig_quarter_rom uRom (
        .idx (idxP1),
        .mag (mag)
    );

    assign magExt  = OUT_W'(mag);
    assign slotVal = negP1 ? -$signed(magExt) : $signed(magExt);

    // Capture and fold registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            angCap  <= angles;
            modeCap <= mode;
        end
        if (state == ST_FOLD) begin
            idxP1 <= foldIdx;
            negP1 <= foldNeg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            chan    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            results <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        chan  <= '0;
                        busy  <= 1'b1;
                        state <= ST_FOLD;
                    end
                end
                ST_FOLD: begin
                    state <= ST_LOOK;
                end
                ST_LOOK: begin
                    results[chan*OUT_W +: OUT_W] <= slotVal;
                    if (chan == LAST_CH) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        chan  <= chan + 1'b1;
                        state <= ST_FOLD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
